serdesphy_prbs_test_ctrl: RTL
=============================

# serdesphy_prbs_test_ctrl

Sequencer for the RX PRBS-7 checker. It runs one bit-error-rate test per `start` request:
- aligns the checker and qualifies lock over a run of clean words;
- clears the error counter and measures over a programmable word window;
- latches the result and reports pass/fail.

It sits between the register/control interface and the PRBS checker, and owns all of the checker's enable and reset controls.

## Interface
- `LOCK_WORDS`, 16: consecutive error-free checked words required to declare lock.
- `MAX_RETRY`, 3: realign attempts after a lock loss before giving up (2-bit range).
- `TIMEOUT_CYCLES`, 4096: idle-word watchdog limit; used only with the macro below.
- `clk` in 1: 24 MHz clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a test; sampled only in IDLE or DONE.
- `abort` in 1: cancel a test from any state.
- `window_len` in 16: measurement window in words; sampled at `start`; 0 is treated as 1.
- `chk_error_count` in 8: checker error counter (saturating at 255).
- `chk_busy` in 1: checker busy flag. Each rising edge counts as one checked word.
- `chk_enable` out 1: checker enable.
- `chk_reset_alignment` out 1: one-cycle pulse.
- `chk_reset_counter` out 1: one-cycle pulse. Never asserted in the same cycle as `chk_reset_alignment`.
- `busy` out 1: test in progress.
- `done` out 1: level; set in DONE and held until the next `start` or `abort`.
- `pass` out 1: valid while `done`=1; 1 when `result_errors`=0.
- `lock_fail` out 1: valid while `done`=1; lock was not achieved within the retry limit.
- `timeout` out 1: valid while `done`=1; the watchdog expired.
- `result_errors` out 8: errors latched at the end of MEASURE.
- `words_checked` out 16: live word count in MEASURE; frozen in DONE.
- `retry_count` out 2: realign attempts used in the current test.

## Operation
- States: IDLE, ALIGN, CLR_A, ACQUIRE, CLR_M, MEASURE, DONE.
- IDLE/DONE → ALIGN on `start`.
  - Latch `window_len`.
  - Clear `done`, `pass`, `lock_fail`, `timeout`, `retry_count`, `words_checked`, `result_errors`.
- ALIGN: assert `chk_reset_alignment` for 1 cycle; `chk_enable`=0. Next state is CLR_A.
- CLR_A: assert `chk_reset_counter` for 1 cycle. Load the baseline register with 0. Next state is ACQUIRE.
- ACQUIRE: `chk_enable`=1. Track `chk_busy` rising edges as words, and compare `chk_error_count` against the baseline every cycle.
  - Count reaches `LOCK_WORDS` with no change in `chk_error_count` → CLR_M.
  - Count changed and `retry_count` < `MAX_RETRY` → `retry_count`+1, then ALIGN.
  - Count changed and `retry_count` = `MAX_RETRY` → DONE with `lock_fail`=1, `pass`=0.
  - Any change in the count resets the clean-word run to 0.
- CLR_M: `chk_enable` stays 1. Assert `chk_reset_counter` for 1 cycle. Next state is MEASURE.
- MEASURE: `chk_enable`=1. Increment `words_checked` on each `chk_busy` rising edge.
  - When it reaches the window length (the latched `window_len`, or 1 if that is 0), go to DONE.
  - Errors do not abort the measurement.
- DONE:
  - `chk_enable`=0.
  - `result_errors` = `chk_error_count` sampled on the MEASURE→DONE transition cycle.
  - `pass` = (`result_errors`==0) && !`lock_fail` && !`timeout`.
  - `done`=1, `busy`=0.
- `abort` (any state) → IDLE on the next edge.
  - All checker controls deasserted; `done`, `pass`, `lock_fail` and `timeout` cleared.
  - `abort` takes priority over a simultaneous `start`.
- `start` is ignored while `busy`=1.
- Saturation: `result_errors` is 255 whenever the checker has saturated.
- `words_checked` does not wrap, because the window length caps it.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, every counter is 0.
- `start` sampled at edge N:
  - `busy`=1 and `chk_reset_alignment`=1 during cycle N+1.
  - `chk_reset_counter`=1 during cycle N+2.
  - `chk_enable`=1 from cycle N+3.
- Word detect uses a registered copy of `chk_busy`. An edge is counted 1 cycle after it occurs.
- `done` rises 1 cycle after the final counted word edge.
- `rst` asserted mid-test forces the reset values immediately, with no clock required.

## Configuration
- `SERDESPHY_PRBS_CTRL_TIMEOUT_EN` defined: a 16-bit watchdog runs in ACQUIRE and MEASURE.
  - It reloads on each counted word.
  - After `TIMEOUT_CYCLES` cycles with no word it goes to DONE with `timeout`=1 and `pass`=0.
- Macro undefined: no watchdog. `timeout` is tied to 0, and the block waits indefinitely for words.

## Test plan
- Clean PRBS stream, `window_len`=100 → `done`=1, `pass`=1, `result_errors`=0, `words_checked`=100, `retry_count`=0.
- One corrupted word injected after lock, `window_len`=50 → `result_errors`=1, `pass`=0, `lock_fail`=0.
- Errors in the first word of every ACQUIRE attempt → 4 ALIGN pulses, then `done`=1, `lock_fail`=1, `retry_count`=3.
- `abort` at `words_checked`=20 → `busy`=0 and `done`=0 on the next cycle, `chk_enable`=0, and no further pulses.
- 300 corrupted words in a 400-word window → `result_errors`=255, `pass`=0.
- With the macro defined and the stream stalled in MEASURE → `timeout`=1 after 4096 cycles. Without the macro → still `busy` at 10000 cycles.

Source files
------------

// File: rtl/serdesphy_prbs_test_ctrl.sv
// Sequencer for the RX PRBS-7 checker: align, qualify lock, measure a word window, report.
// Optional idle-word watchdog is built when SERDESPHY_PRBS_CTRL_TIMEOUT_EN is defined.
module serdesphy_prbs_test_ctrl #(
   parameter int unsigned LOCK_WORDS     = 16,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] window_len,
   input  logic [7:0]  chk_error_count,
   input  logic        chk_busy,
   output logic        chk_enable,
   output logic        chk_reset_alignment,
   output logic        chk_reset_counter,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        lock_fail,
   output logic        timeout,
   output logic [7:0]  result_errors,
   output logic [15:0] words_checked,
   output logic [1:0]  retry_count
);
   typedef enum logic [2:0] {
      StIdle, StAlign, StClrA, StAcquire, StClrM, StMeasure, StDone
   } state_e;

   localparam logic [15:0] LockLast = 16'(LOCK_WORDS - 1);
   localparam logic [1:0]  MaxRetry = 2'(MAX_RETRY);

   state_e      state_q, state_d;
   logic [15:0] window_q, window_d;
   logic [15:0] clean_q, clean_d;
   logic [15:0] words_q, words_d;
   logic [7:0]  baseline_q, baseline_d;
   logic [7:0]  result_q, result_d;
   logic [1:0]  retry_q, retry_d;
   logic        done_q, done_d, pass_q, pass_d;
   logic        lock_fail_q, lock_fail_d, timeout_q, timeout_d;
   logic        enable_q, enable_d, rst_align_q, rst_align_d;
   logic        rst_cnt_q, rst_cnt_d, busy_q, busy_d;
   logic        chk_busy_q;
   logic        word_edge, wd_expired;
   logic [15:0] window_eff;

   assign word_edge  = chk_busy & ~chk_busy_q;
   assign window_eff = (window_q == 16'd0) ? 16'd1 : window_q;

`ifdef SERDESPHY_PRBS_CTRL_TIMEOUT_EN
   localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_q;
   logic        watching;

   assign watching = (state_q == StAcquire) || (state_q == StMeasure);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (!watching || word_edge) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 16'd1;
      end
   end

   assign wd_expired = watching && !word_edge && (wd_q == WdLast);
`else
   logic unused_wd_cfg;
   assign unused_wd_cfg = ^TIMEOUT_CYCLES;
   assign wd_expired    = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      window_d    = window_q;
      clean_d     = clean_q;
      words_d     = words_q;
      baseline_d  = baseline_q;
      result_d    = result_q;
      retry_d     = retry_q;
      done_d      = done_q;
      pass_d      = pass_q;
      lock_fail_d = lock_fail_q;
      timeout_d   = timeout_q;
      if (abort) begin
         state_d     = StIdle;
         done_d      = 1'b0;
         pass_d      = 1'b0;
         lock_fail_d = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d     = StAlign;
                  window_d    = window_len;
                  done_d      = 1'b0;
                  pass_d      = 1'b0;
                  lock_fail_d = 1'b0;
                  timeout_d   = 1'b0;
                  retry_d     = '0;
                  words_d     = '0;
                  result_d    = '0;
               end
            end
            StAlign: state_d = StClrA;
            StClrA: begin
               baseline_d = '0;
               clean_d    = '0;
               state_d    = StAcquire;
            end
            StAcquire: begin
               // Any movement of the error counter breaks the clean run and forces a realign.
               if (chk_error_count != baseline_q) begin
                  baseline_d = chk_error_count;
                  clean_d    = '0;
                  if (retry_q < MaxRetry) begin
                     retry_d = retry_q + 2'd1;
                     state_d = StAlign;
                  end else begin
                     state_d     = StDone;
                     done_d      = 1'b1;
                     lock_fail_d = 1'b1;
                     pass_d      = 1'b0;
                  end
               end else if (wd_expired) begin
                  state_d   = StDone;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  pass_d    = 1'b0;
               end else if (word_edge) begin
                  if (clean_q == LockLast) state_d = StClrM;
                  else clean_d = clean_q + 16'd1;
               end
            end
            StClrM: state_d = StMeasure;
            StMeasure: begin
               if (word_edge) begin
                  words_d = words_q + 16'd1;
                  if ((words_q + 16'd1) == window_eff) begin
                     state_d  = StDone;
                     done_d   = 1'b1;
                     result_d = chk_error_count;
                     pass_d   = (chk_error_count == 8'd0);
                  end
               end else if (wd_expired) begin
                  state_d   = StDone;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  pass_d    = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      // Checker controls are decoded from the next state so they are registered outputs.
      enable_d    = state_d inside {StAcquire, StClrM, StMeasure};
      rst_align_d = (state_d == StAlign);
      rst_cnt_d   = state_d inside {StClrA, StClrM};
      busy_d      = !(state_d inside {StIdle, StDone});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         window_q    <= '0;
         clean_q     <= '0;
         words_q     <= '0;
         baseline_q  <= '0;
         result_q    <= '0;
         retry_q     <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         lock_fail_q <= 1'b0;
         timeout_q   <= 1'b0;
         enable_q    <= 1'b0;
         rst_align_q <= 1'b0;
         rst_cnt_q   <= 1'b0;
         busy_q      <= 1'b0;
         chk_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         window_q    <= window_d;
         clean_q     <= clean_d;
         words_q     <= words_d;
         baseline_q  <= baseline_d;
         result_q    <= result_d;
         retry_q     <= retry_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         lock_fail_q <= lock_fail_d;
         timeout_q   <= timeout_d;
         enable_q    <= enable_d;
         rst_align_q <= rst_align_d;
         rst_cnt_q   <= rst_cnt_d;
         busy_q      <= busy_d;
         chk_busy_q  <= chk_busy;
      end
   end

   assign chk_enable          = enable_q;
   assign chk_reset_alignment = rst_align_q;
   assign chk_reset_counter   = rst_cnt_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign pass                = pass_q;
   assign lock_fail           = lock_fail_q;
   assign timeout             = timeout_q;
   assign result_errors       = result_q;
   assign words_checked       = words_q;
   assign retry_count         = retry_q;
endmodule
